// File: rtl/ahb_dma_com_pkg.sv
// Shared AHB encodings and address-phase control bundle for the DMA/COM bus matrix.
// Used by the input stages and by the output-stage arbiter.
package ahb_dma_com_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Address-phase controls that travel with the address through the hold register.
    typedef struct packed {
        htrans_e     trans;
        logic        write;
        logic [2:0]  size;
        hburst_e     burst;
        logic [3:0]  prot;
        logic        lock;
    } ahb_ctrl_t;

    // NONSEQ and SEQ carry a transfer; IDLE and BUSY never request the bus.
    function automatic logic trans_is_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage

// File: rtl/ahb_addr_hold_reg_dma_com.sv
// Load-enabled address-phase register bank with asynchronous clear.
// Captures one master address phase while the target output stage is unavailable.
module ahb_addr_hold_reg_dma_com
    import ahb_dma_com_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  ahb_ctrl_t         ctrl_i,
    output logic [ADDR_W-1:0] addr_o,
    output ahb_ctrl_t         ctrl_o
);

    logic [ADDR_W-1:0] addr_q;
    ahb_ctrl_t         ctrl_q;

    // Capture the live address phase on load; cleared asynchronously on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
            ctrl_q <= '0;
        end else if (load_i) begin
            addr_q <= addr_i;
            ctrl_q <= ctrl_i;
        end
    end

    assign addr_o = addr_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/ahb_input_stage_dma_com.sv
// Per-master input stage of the DMA/COM AHB matrix. Presents the master's address phase to
// the decoder/output stage (combinationally when granted, from a hold register otherwise),
// raises the arbiter request and stretches the master while a held transfer is pending.
// Optional feature: DMA_COM_SEQ_REMAP_EN re-issues a held SEQ beat as NONSEQ/INCR and keeps
// the rest of the broken burst on INCR until the master starts a new burst or goes idle.
module ahb_input_stage_dma_com
    import ahb_dma_com_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSELS,
    input  logic [ADDR_W-1:0] HADDRS,
    input  logic [1:0]        HTRANSS,
    input  logic              HWRITES,
    input  logic [2:0]        HSIZES,
    input  logic [2:0]        HBURSTS,
    input  logic [3:0]        HPROTS,
    input  logic              HMASTLOCKS,
    input  logic              HREADYS,
    input  logic              trans_granted,
    input  logic              HREADYM,
    input  logic              HRESPM,
    output logic [ADDR_W-1:0] HADDRM,
    output logic [1:0]        HTRANSM,
    output logic              HWRITEM,
    output logic [2:0]        HSIZEM,
    output logic [2:0]        HBURSTM,
    output logic [3:0]        HPROTM,
    output logic              HMASTLOCKM,
    output logic              active_trans,
    output logic              held_tran,
    output logic              HREADYOUTS,
    output logic              HRESPS
);

    logic              held_q, held_d;
    logic              dphase_q, dphase_d;
    logic              accept, out_ready, hold_set, hold_clr, err_drop, issue_live;
    ahb_ctrl_t         live_ctrl, live_ctrl_eff, hold_ctrl, hold_ctrl_eff, pres_ctrl;
    logic [ADDR_W-1:0] hold_addr;

    // A held transfer always stalls the master, so a new accept cannot overlap a hold.
    assign accept     = HSELS & HREADYS & trans_is_active(HTRANSS) & ~held_q;
    assign out_ready  = trans_granted & HREADYM;
    // Second ERROR cycle while holding: discard the pending transfer instead of issuing it.
    assign err_drop   = held_q & dphase_q & HRESPM & HREADYM;
    assign hold_clr   = held_q & out_ready & ~err_drop;
    assign hold_set   = accept & ~out_ready;
    assign issue_live = accept & out_ready;

    // Assemble the live address-phase controls from the master inputs.
    always_comb begin
        live_ctrl       = '0;
        live_ctrl.trans = htrans_e'(HTRANSS);
        live_ctrl.write = HWRITES;
        live_ctrl.size  = HSIZES;
        live_ctrl.burst = hburst_e'(HBURSTS);
        live_ctrl.prot  = HPROTS;
        live_ctrl.lock  = HMASTLOCKS;
    end

    ahb_addr_hold_reg_dma_com #(
        .ADDR_W (ADDR_W)
    ) u_hold_reg (
        .clk_i  (HCLK),
        .rst_ni (HRESETn),
        .load_i (hold_set),
        .addr_i (HADDRS),
        .ctrl_i (live_ctrl),
        .addr_o (hold_addr),
        .ctrl_o (hold_ctrl)
    );

`ifdef DMA_COM_SEQ_REMAP_EN
    logic broken_q, broken_d;

    // Track a burst whose continuity was lost while a SEQ beat sat in the hold register.
    always_comb begin
        broken_d = broken_q;
        if (hold_clr && hold_ctrl.trans == HTRANS_SEQ) begin
            broken_d = 1'b1;
        end else if (HREADYS && !held_q &&
                     (HTRANSS == HTRANS_IDLE || HTRANSS == HTRANS_NONSEQ)) begin
            broken_d = 1'b0;
        end
    end

    // Broken-burst flag register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            broken_q <= 1'b0;
        end else begin
            broken_q <= broken_d;
        end
    end

    // Re-issue a held SEQ as the start of an undefined-length burst; later beats stay INCR.
    always_comb begin
        hold_ctrl_eff = hold_ctrl;
        live_ctrl_eff = live_ctrl;
        if (hold_ctrl.trans == HTRANS_SEQ) begin
            hold_ctrl_eff.trans = HTRANS_NONSEQ;
            hold_ctrl_eff.burst = HBURST_INCR;
        end
        if (broken_q && live_ctrl.trans == HTRANS_SEQ) begin
            live_ctrl_eff.burst = HBURST_INCR;
        end
    end
`else
    // Held transfers are re-issued exactly as the master presented them.
    always_comb begin
        hold_ctrl_eff = hold_ctrl;
        live_ctrl_eff = live_ctrl;
    end
`endif

    // Output mux: registered transfer while holding, otherwise the live master phase.
    always_comb begin
        pres_ctrl = held_q ? hold_ctrl_eff : live_ctrl_eff;
        HADDRM    = held_q ? hold_addr : HADDRS;
    end

    assign HTRANSM    = err_drop ? HTRANS_IDLE : pres_ctrl.trans;
    assign HWRITEM    = pres_ctrl.write;
    assign HSIZEM     = pres_ctrl.size;
    assign HBURSTM    = pres_ctrl.burst;
    assign HPROTM     = pres_ctrl.prot;
    assign HMASTLOCKM = pres_ctrl.lock;

    assign active_trans = held_q | (HSELS & trans_is_active(HTRANSS));
    assign held_tran    = held_q;
    assign HREADYOUTS   = held_q ? 1'b0 : (dphase_q ? HREADYM : 1'b1);
    assign HRESPS       = dphase_q ? HRESPM : HRESP_OKAY;

    // Next-state for the hold flag and the data-phase flag.
    always_comb begin
        held_d = held_q;
        if (hold_clr || err_drop) begin
            held_d = 1'b0;
        end else if (hold_set) begin
            held_d = 1'b1;
        end

        dphase_d = dphase_q;
        if (issue_live || hold_clr) begin
            dphase_d = 1'b1;
        end else if (HREADYM) begin
            dphase_d = 1'b0;
        end
    end

    // Hold and data-phase state registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_q   <= 1'b0;
            dphase_q <= 1'b0;
        end else begin
            held_q   <= held_d;
            dphase_q <= dphase_d;
        end
    end

endmodule

// File: doc/ahb_input_stage_dma_com.md
# ahb_input_stage_dma_com

Per-master input stage of the DMA/COM AHB bus matrix; sits directly upstream of the round-robin output-stage arbiter. Accepts master address phases, produces the per-port request that feeds the arbiter (`req_portN`), and holds a transfer in a register while the target output stage is not granted or not ready. Stretches the master with HREADYOUTS low until the held transfer is issued. One instance per master port (DMA, COM).

## Interface
- ADDR_W, default 32: address width.
- HCLK  in  1  AHB clock.
- HRESETn  in  1  reset; asynchronous assert, active-low.
- HSELS, HWRITES, HMASTLOCKS, HREADYS  in  1 each  master-side select, write, lock, bus HREADY.
- HADDRS  in  ADDR_W  master address.
- HTRANSS in 2, HSIZES in 3, HBURSTS in 3, HPROTS in 4  master address-phase controls.
- trans_granted  in  1  arbiter has this port selected (`addr_in_port` matches, `no_port` low).
- HREADYM  in  1  ready from the output stage.
- HRESPM  in  1  response from the output stage.
- HADDRM, HTRANSM, HWRITEM, HSIZEM, HBURSTM, HPROTM, HMASTLOCKM  out  matching widths  transfer presented to decoder/output stage.
- active_trans  out  1  request to arbiter.
- held_tran  out  1  a transfer is registered and pending.
- HREADYOUTS  out  1  ready to master.
- HRESPS  out  1  response to master.

## Operation
- accept = HSELS & HREADYS & HTRANSS[1] (NONSEQ or SEQ).
- hold_set = accept & ~(trans_granted & HREADYM). On hold_set, load all address-phase fields into the hold register and set held_tran.
- hold_clr = held_tran & trans_granted & HREADYM; clears held_tran. hold_clr has priority over a new accept only if the master is stalled, and the master is always stalled while held, so the two cannot coincide.
- Output mux: held_tran ? registered fields : live master fields. Live path is combinational.
- active_trans = held_tran | (HSELS & HTRANSS[1]). IDLE/BUSY are never requested.
- HMASTLOCKM is passed through in the same way, so the arbiter holds the grant.
- dphase register: set on (accept & trans_granted & HREADYM) or hold_clr; cleared when HREADYM is high and no new issue occurs.
- HREADYOUTS = held_tran ? 0 : (dphase ? HREADYM : 1).
- HRESPS = dphase ? HRESPM : OKAY(0).
- ERROR: if HRESPM=1 while held_tran=1, the held transfer is discarded on the second ERROR cycle (HREADYM high).

## Timing
- Reset values:
  - held_tran=0, dphase=0, hold register=0.
  - HREADYOUTS=1, HRESPS=0, active_trans=0.
  - HTRANSM: follows the live input.
- Granted path: zero-cycle latency (master signals to HxxxM combinational).
- Not granted: held_tran rises on the next HCLK edge. The master sees HREADYOUTS low from that cycle. Minimum stall is 1 cycle.
- Held transfer issues in the cycle trans_granted & HREADYM. held_tran falls on the following edge, and HREADYOUTS then tracks HREADYM for the data phase.
- HRESETn low mid-hold: the held transfer is dropped asynchronously and all outputs return to reset values.

## Configuration
- DMA_COM_SEQ_REMAP_EN defined:
  - A transfer that was held because the grant was lost mid-burst (registered SEQ) is re-issued as HTRANSM=NONSEQ, HBURSTM=INCR(001).
  - A broken_burst flag keeps HBURSTM=INCR for subsequent SEQ beats until the master issues a NONSEQ or IDLE.
- Undefined: held transfers are re-issued unchanged, so the output stage relies on the master's original burst type.

## Structure
- Shared package ahb_dma_com_pkg: HTRANS encodings (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11), HBURST encodings (SINGLE 000 … INCR16 111), OKAY/ERROR constants.
- The arbiter imports the same package.
- One sub-module, ahb_addr_hold_reg_dma_com: the load-enabled address-phase register bank with async clear.
- Mux, dphase, and ready/response logic stay in the top.

## Test plan
- Granted single write: HADDRS=0x2000_0010, NONSEQ/SINGLE, trans_granted=1, HREADYM=1 -> HADDRM equals it in the same cycle; held_tran=0; HREADYOUTS=1.
- Not granted: NONSEQ to 0x4000_0000, trans_granted=0 for 3 cycles -> held_tran=1 and HREADYOUTS=0 for 3 cycles. On grant, HADDRM=0x4000_0000 from the register, then held_tran=0.
- INCR4 burst with grant lost at beat 3 (SEQ, 0x..08), with macro -> re-issued HTRANSM=10, HBURSTM=001. Beat 4 is also HBURSTM=001. Without the macro -> HTRANSM=11, HBURSTM=011.
- Wait states: granted transfer, HREADYM low 2 cycles in the data phase -> HREADYOUTS low exactly 2 cycles; no hold.
- ERROR: HRESPM=1 for 2 cycles (HREADYM 0 then 1) with the next transfer held -> HRESPS=1 both cycles; held_tran=0 after the second.
- Reset mid-hold: assert HRESETn=0 while held_tran=1 -> held_tran=0, HREADYOUTS=1, active_trans=0 immediately, without a clock edge.
